// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester that turns valid/ready commands into SETUP/ACCESS transfers.
// Optional ACCESS wait-state abort is compiled in with APB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module apb_master #(
  parameter int ADDR_BUS_WIDTH = 32,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int TIMEOUT_CYC    = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_BUS_WIDTH-1:0] cmd_addr,
  input  logic [DATA_BUS_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [DATA_BUS_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_slverr,
  output logic                      rsp_timeout,
  output logic                      PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDR_BUS_WIDTH-1:0] PADDR,
  output logic [DATA_BUS_WIDTH-1:0] PWDATA,
  input  logic [DATA_BUS_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                    r_state;
  logic                      r_live;
  logic                      r_psel;
  logic                      r_penable;
  logic                      r_pwrite;
  logic [ADDR_BUS_WIDTH-1:0] r_paddr;
  logic [DATA_BUS_WIDTH-1:0] r_pwdata;
  logic                      r_rsp_valid;
  logic [DATA_BUS_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_slverr;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_timeout;
  logic             w_expire;

  // Fires on the TIMEOUT_CYC-th consecutive ACCESS edge that still sees no PREADY.
  assign w_expire    = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) && !PREADY;
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  // r_live keeps cmd_ready low while reset is held and until the first edge after release.
  assign cmd_ready  = r_live && (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_slverr = r_rsp_slverr;
  assign PSEL       = r_psel;
  assign PENABLE    = r_penable;
  assign PWRITE     = r_pwrite;
  assign PADDR      = r_paddr;
  assign PWDATA     = r_pwdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= IDLE;
      r_live        <= 1'b0;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_slverr  <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_wait_cnt    <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      r_live      <= 1'b1;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_live) begin
            r_paddr   <= cmd_addr;
            r_pwrite  <= cmd_write;
            r_pwdata  <= cmd_write ? cmd_wdata : '0;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            r_rsp_valid  <= 1'b1;
            r_rsp_slverr <= PSLVERR;
            r_rsp_rdata  <= (!r_pwrite && !PSLVERR) ? PRDATA : '0;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_state      <= IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (w_expire) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_slverr  <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_rdata   <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master against a small APB slave model.
// Build with APB_MASTER_TIMEOUT_EN defined to exercise the wait-state abort path.
`timescale 1ns/1ps
module tb_apb_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_slverr, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  apb_master #(.ADDR_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // Slave model: programmable wait states, error at 0x100, optional permanent stall.
  bit [31:0] mem [0:511];
  int        slv_waits = 0;
  logic      slv_stall = 1'b0;
  int        wcnt = 0;

  assign PREADY  = PSEL && PENABLE && !slv_stall && (wcnt == slv_waits);
  assign PSLVERR = PSEL && PENABLE && (PADDR == 32'h100);
  assign PRDATA  = (PADDR == 32'h100) ? 32'hBAD0_BAD0 : mem[PADDR[8:0]];

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) mem[PADDR[8:0]] <= PWDATA;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command for one edge; returns at the negedge after acceptance (k=1).
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Wait for rsp_valid; lat is the negedge index counted from acceptance.
  task automatic wait_rsp(input string tag, input int budget, output int lat);
    lat = 1;
    while (!rsp_valid && lat < budget) begin
      @(negedge PCLK);
      lat++;
    end
    check_val({tag, "_seen"}, rsp_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, hi, seen, idx, nrsp, last, psel_lo;
    logic started, acc;
    logic [31:0] rd [4];
    logic        b_w [4];
    logic [31:0] b_a [4];
    logic [31:0] b_d [4];

    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (2) @(negedge PCLK);
    check_val("rst_outs", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_slverr, rsp_timeout}, 0);
    check_val("rst_paddr", PADDR, 0);
    check_val("rst_pwdata", PWDATA, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_val("rst_ready", cmd_ready, 1);

    // Zero-wait write 0xDEADBEEF -> 0x10
    send_cmd(1'b1, 32'h10, 32'hDEADBEEF);
    check_val("t1_setup", {PSEL, PENABLE, PWRITE, cmd_ready}, 4'b1010);
    check_val("t1_paddr", PADDR, 32'h10);
    check_val("t1_pwdata", PWDATA, 32'hDEADBEEF);
    @(negedge PCLK);
    check_val("t1_access", {PSEL, PENABLE, rsp_valid}, 3'b110);
    @(negedge PCLK);
    check_val("t1_rsp", {rsp_valid, rsp_slverr, rsp_timeout, cmd_ready, PSEL, PENABLE}, 6'b100100);
    check_val("t1_rdata", rsp_rdata, 0);
    check_val("t1_mem", mem[9'h10], 32'hDEADBEEF);
    @(negedge PCLK);
    check_val("t1_pulse", rsp_valid, 0);
    check_val("t1_hold", {PWRITE, PADDR, PWDATA}, {1'b1, 32'h10, 32'hDEADBEEF});

    // Read 0x10 with 2 wait states
    slv_waits = 2;
    send_cmd(1'b0, 32'h10, 32'h1111_1111);
    check_val("t2_pwdata", PWDATA, 0);
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      check_val("t2_stable", {PSEL, PENABLE, PWRITE, rsp_valid, PADDR}, {4'b1100, 32'h10});
      @(negedge PCLK);
    end
    check_val("t2_rsp", {rsp_valid, rsp_slverr, cmd_ready, PSEL}, 4'b1010);
    check_val("t2_rdata", rsp_rdata, 32'hDEADBEEF);
    @(negedge PCLK);
    check_val("t2_pulse", rsp_valid, 0);
    check_val("t2_rhold", rsp_rdata, 32'hDEADBEEF);

    // Slave error on read of 0x100
    slv_waits = 0;
    send_cmd(1'b0, 32'h100, 32'h0);
    wait_rsp("t3", 10, lat);
    check_val("t3_lat", lat, 3);
    check_val("t3_slverr", rsp_slverr, 1);
    check_val("t3_rdata", rsp_rdata, 0);
    @(negedge PCLK);

    // Back-to-back commands with cmd_valid held high
    b_w = '{1'b1, 1'b0, 1'b1, 1'b0};
    b_a = '{32'h1, 32'h1, 32'h2, 32'h2};
    b_d = '{32'hA5, 32'h0, 32'h5A, 32'h0};
    idx = 0; nrsp = 0; last = 0; psel_lo = 0; started = 1'b0;
    cmd_write = b_w[0]; cmd_addr = b_a[0]; cmd_wdata = b_d[0]; cmd_valid = 1'b1;
    for (int cyc = 1; cyc <= 40 && nrsp < 4; cyc++) begin
      acc = cmd_ready && cmd_valid;
      @(negedge PCLK);
      if (acc) begin
        idx++;
        if (idx < 4) begin
          cmd_write = b_w[idx]; cmd_addr = b_a[idx]; cmd_wdata = b_d[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (PSEL) started = 1'b1;
      else if (started) psel_lo++;
      if (rsp_valid) begin
        if (nrsp > 0) check_val("t4_gap", cyc - last, 3);
        rd[nrsp] = rsp_rdata;
        last = cyc;
        nrsp++;
      end
    end
    cmd_valid = 1'b0;
    check_val("t4_nrsp", nrsp, 4);
    check_val("t4_rd1", rd[1], 32'hA5);
    check_val("t4_rd3", rd[3], 32'h5A);
    check_val("t4_psel_lo", psel_lo, 4);
    @(negedge PCLK);

    // PREADY stuck low
    slv_stall = 1'b1;
    send_cmd(1'b0, 32'h10, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
    wait_rsp("t5", 20, lat);
    check_val("t5_lat", lat, 6);
    check_val("t5_flags", {rsp_timeout, rsp_slverr, PSEL, PENABLE}, 4'b1100);
    check_val("t5_rdata", rsp_rdata, 0);
    @(negedge PCLK);
`else
    hi = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (PSEL) hi++;
      if (rsp_valid) seen++;
      @(negedge PCLK);
    end
    check_val("t5_psel_hi", hi, 100);
    check_val("t5_no_rsp", seen, 0);
    check_val("t5_no_to", rsp_timeout, 0);
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
`endif
    slv_stall = 1'b0;

    // Reset asserted during ACCESS of a read
    slv_waits = 5;
    send_cmd(1'b0, 32'h10, 32'h0);
    @(negedge PCLK);
    check_val("t6_in_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESETn = 1'b0;
    #1 check_val("t6_async", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0000);
    @(negedge PCLK);
    PRESETn = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    check_val("t6_no_rsp", seen, 0);
    check_val("t6_ready", cmd_ready, 1);
    slv_waits = 0;
    send_cmd(1'b1, 32'h20, 32'hCAFEF00D);
    wait_rsp("t6w", 10, lat);
    check_val("t6_lat", lat, 3);
    check_val("t6_slverr", rsp_slverr, 0);
    check_val("t6_mem", mem[9'h20], 32'hCAFEF00D);
    @(negedge PCLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that converts a valid/ready command interface into APB SETUP/ACCESS transfers. It returns read data, PSLVERR and an optional timeout status on a one-cycle response strobe. It is the initiator counterpart of the APB SRAM slave. It sits between a local controller or bench sequencer and any APB slave on the same PCLK domain.

## Interface
Parameters:
- ADDR_BUS_WIDTH, 32, width of PADDR and cmd_addr
- DATA_BUS_WIDTH, 32, width of PWDATA/PRDATA/cmd_wdata/rsp_rdata
- TIMEOUT_CYC, 16, ACCESS cycles without PREADY before abort (used only with APB_MASTER_TIMEOUT_EN; legal range ≥1)

Ports:
- Clocking and reset: one clock, PCLK; reset is asynchronous and active-low, PRESETn.
- PCLK  in  1  clock; all state changes on rising edge
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command; high iff state==IDLE (combinational from state)
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_BUS_WIDTH  target address
- cmd_wdata  in  DATA_BUS_WIDTH  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_BUS_WIDTH  read data; 0 for writes and timeouts
- rsp_slverr  out  1  PSLVERR captured, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_BUS_WIDTH  APB address
- PWDATA  out  DATA_BUS_WIDTH  APB write data
- PRDATA  in  DATA_BUS_WIDTH  APB read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- States: IDLE, SETUP, ACCESS. Reset state is IDLE.
- All APB and rsp_* outputs are registered. Reset value of every output is 0, including cmd_ready until reset releases. cmd_ready is 1 in IDLE after reset.
- IDLE: on an edge with cmd_valid=1, the command is accepted and the state moves to SETUP.
  - Load PADDR=cmd_addr and PWRITE=cmd_write.
  - Load PWDATA=cmd_wdata for writes, 0 for reads.
  - Set PSEL=1, PENABLE=0.
- SETUP: the next edge sets PENABLE=1 and moves the state to ACCESS. PREADY and PSLVERR are ignored in this state.
- ACCESS, PREADY=1 at an edge:
  - Set rsp_valid=1.
  - Set rsp_slverr=PSLVERR.
  - Set rsp_rdata=PRDATA if the transfer is a read and PSLVERR=0; otherwise rsp_rdata=0.
  - Set rsp_timeout=0.
  - Set PSEL=0, PENABLE=0 and return to IDLE.
- ACCESS, PREADY=0: hold all APB outputs stable. Wait states are unbounded unless the timeout is compiled in.
- rsp_valid is high for exactly one cycle. rsp_rdata, rsp_slverr and rsp_timeout hold their values until the next response.
- After a transfer, PADDR and PWRITE keep their last values in IDLE. PWDATA keeps its last value too.
- Commands are never dropped or queued. cmd_valid is ignored outside IDLE.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronously), no response is issued, and the state returns to IDLE.

## Timing
- Command accepted at edge T0: PSEL=1 after T0, and PENABLE=1 after T0+1.
- With no wait states, PREADY is sampled at T0+2. rsp_valid is high in the cycle after T0+2, and cmd_ready is high in that same cycle.
- The next command can be accepted at T0+3. Zero-wait throughput is one transfer per 3 cycles.
- Each wait state (PREADY=0 in ACCESS) adds one cycle to the latency.
- PSEL never falls between SETUP and ACCESS of the same transfer. No back-to-back ACCESS without an intervening IDLE cycle.

## Configuration
- Macro APB_MASTER_TIMEOUT_EN.
- Defined: a wait counter of width $clog2(TIMEOUT_CYC+1) clears on entry to ACCESS and increments at each ACCESS edge with PREADY=0.
  - If the TIMEOUT_CYC-th consecutive ACCESS edge still has PREADY=0, the transfer aborts:
    - rsp_valid=1, rsp_slverr=1, rsp_timeout=1, rsp_rdata=0.
    - PSEL=0, PENABLE=0, and the state returns to IDLE.
  - If PREADY=1 on that same edge, the normal completion wins.
- Undefined: no counter is present, rsp_timeout is tied to 0, and the block waits on PREADY indefinitely.

## Test plan
- Write 0xDEADBEEF to 0x10 with zero wait:
  - PSEL rises the cycle after acceptance and PENABLE rises one cycle later.
  - rsp_valid pulses at acceptance+3 with rsp_slverr=0 and rsp_rdata=0.
  - The slave model holds 0xDEADBEEF at 0x10.
- Read 0x10 with 2 wait states: APB outputs are stable for 3 ACCESS cycles, then rsp_rdata=0xDEADBEEF, rsp_valid pulses once, and cmd_ready=1 in the same cycle.
- Read 0x100 where the slave returns PSLVERR=1 with PREADY=1: rsp_slverr=1 and rsp_rdata=0.
- cmd_valid held high for 4 commands (W 0x1=0xA5, R 0x1, W 0x2=0x5A, R 0x2): exactly 4 rsp_valid pulses 3 cycles apart, reads return 0xA5 and 0x5A, and PSEL drops for one cycle between transfers.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=4, PREADY tied low: abort after 4 ACCESS edges with rsp_timeout=1, rsp_slverr=1, PSEL=0. Without the macro, PSEL stays high for 100 cycles.
- PRESETn low during ACCESS of a read: PSEL, PENABLE and rsp_valid go to 0 immediately with no response. After release, cmd_ready=1 and a new write completes normally.
